// File: rtl/sound_frame_sched.sv
// Sample-playback scheduler: a CPU-fed byte FIFO drained one 4-channel frame per
// timer tick onto the Soundrive DAC write port, with direct CPU writes overriding.
module sound_frame_sched #(
  parameter int          FIFO_AW   = 4,
  parameter logic [15:0] DIV_RST   = 16'd874,
  parameter logic [15:0] SDRV_BASE = 16'h000F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             fifo_wr,
  input  logic             fifo_flush,
  input  logic             div_lo_wr,
  input  logic             div_hi_wr,
  input  logic             enable,
  input  logic             cpu_wr,
  input  logic [1:0]       cpu_sel,
  input  logic             flag_clr,
  output logic             sdrv_wr,
  output logic [15:0]      sdrv_addr,
  output logic [7:0]       sdrv_data,
  output logic [FIFO_AW:0] fifo_level,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             busy,
  output logic             underrun,
  output logic             overflow
);

  // Handshake: every CPU strobe is a one-cycle request that is always accepted
  // (no ready); sdrv_wr is a one-cycle valid toward a DAC block that never stalls.

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [15:0] chan_addr(input logic [1:0] n);
    return SDRV_BASE | {9'b0, n[1], 1'b0, n[0], 4'b0};
  endfunction

  state_t             state;
  logic [1:0]         ch;
  logic               pending;
  logic [15:0]        cnt;
  logic [15:0]        div;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;

  logic tick, pop, push_ok, push_drop, start, have_frame, tick_drop;

  assign fifo_full  = (fifo_level == LVL_FULL);
  assign fifo_empty = (fifo_level == '0);
  assign busy       = (state == SEND);

  always_comb begin
    tick       = enable && (cnt == 16'd0);
    pop        = (state == SEND) && !cpu_wr && !fifo_flush;
    push_ok    = fifo_wr && !fifo_flush && (!fifo_full || pop);
    push_drop  = fifo_wr && !fifo_flush && fifo_full && !pop;
    start      = (state == IDLE) && pending;
    have_frame = |fifo_level[FIFO_AW:2];
    // A tick landing in the same cycle the old one is consumed is not a loss.
    tick_drop  = tick && pending && !start;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= 2'd0;
      pending    <= 1'b0;
      cnt        <= DIV_RST;
      div        <= DIV_RST;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      sdrv_wr    <= 1'b0;
      sdrv_addr  <= SDRV_BASE;
      sdrv_data  <= 8'd0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (div_lo_wr) div[7:0]  <= data_in;
      if (div_hi_wr) div[15:8] <= data_in;

      if (!enable || cnt == 16'd0) cnt <= div;
      else                         cnt <= cnt - 16'd1;

      if (!enable)    pending <= 1'b0;
      else if (tick)  pending <= 1'b1;
      else if (start) pending <= 1'b0;

      if (fifo_flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        case ({push_ok, pop})
          2'b10:   fifo_level <= fifo_level + LVL_ONE;
          2'b01:   fifo_level <= fifo_level - LVL_ONE;
          default: fifo_level <= fifo_level;
        endcase
      end

      case (state)
        IDLE: begin
          if (start && have_frame && !fifo_flush) begin
            state <= SEND;
            ch    <= 2'd0;
          end
        end
        SEND: begin
          if (fifo_flush) begin
            state <= IDLE;
          end else if (pop) begin
            ch <= ch + 2'd1;
            if (ch == 2'd3) state <= IDLE;
          end
        end
      endcase

      sdrv_wr <= cpu_wr || pop;
      if (cpu_wr) begin
        sdrv_addr <= chan_addr(cpu_sel);
        sdrv_data <= data_in;
      end else if (pop) begin
        sdrv_addr <= chan_addr(ch);
        sdrv_data <= mem[rd_ptr];
      end

      if (tick_drop || (start && !have_frame)) underrun <= 1'b1;
      else if (flag_clr)                       underrun <= 1'b0;

      if (push_drop)     overflow <= 1'b1;
      else if (flag_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sound_frame_sched.sv
// Directed, randomized-data bench for sound_frame_sched: byte-queue model plus an
// expected-write scoreboard checked by a negedge monitor.
module tb_sound_frame_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        fifo_wr, fifo_flush, div_lo_wr, div_hi_wr, enable, cpu_wr, flag_clr;
  logic [1:0]  cpu_sel;
  logic        sdrv_wr;
  logic [15:0] sdrv_addr;
  logic [7:0]  sdrv_data;
  logic [4:0]  fifo_level;
  logic        fifo_full, fifo_empty, busy, underrun, overflow;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  model_q[$];
  int          wr_cyc[$];
  logic [23:0] got, want;

  sound_frame_sched dut (
    .clk(clk), .rst(rst), .data_in(data_in), .fifo_wr(fifo_wr),
    .fifo_flush(fifo_flush), .div_lo_wr(div_lo_wr), .div_hi_wr(div_hi_wr),
    .enable(enable), .cpu_wr(cpu_wr), .cpu_sel(cpu_sel), .flag_clr(flag_clr),
    .sdrv_wr(sdrv_wr), .sdrv_addr(sdrv_addr), .sdrv_data(sdrv_data),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .busy(busy), .underrun(underrun), .overflow(overflow)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=cycle %0d expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every DAC write must match the head of exp_q
  always @(negedge clk) begin
    if (sdrv_wr === 1'b1) begin
      got = {sdrv_addr, sdrv_data};
      wr_cyc.push_back(cyc);
      checks++;
      assert (exp_q.size() > 0)
        else begin errors++; $error("FAIL unexpected_wr observed=%h expected=none", got); end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checks++;
        assert (got === want)
          else begin errors++; $error("FAIL sdrv_write observed=%h expected=%h", got, want); end
      end
    end
  end

  function automatic logic [15:0] ch_addr(input int n);
    logic [15:0] a;
    a = 16'h000F;
    if ((n & 2) != 0) a = a | 16'h0040;
    if ((n & 1) != 0) a = a | 16'h0010;
    return a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    data_in = b;
    fifo_wr = 1'b1;
    cycle();
    fifo_wr = 1'b0;
    if (model_q.size() < 16) model_q.push_back(b);
  endtask

  task automatic set_div(input logic [15:0] d);
    data_in = d[7:0];  div_lo_wr = 1'b1; cycle(); div_lo_wr = 1'b0;
    data_in = d[15:8]; div_hi_wr = 1'b1; cycle(); div_hi_wr = 1'b0;
    cycle();
  endtask

  task automatic pulse_flag_clr();
    flag_clr = 1'b1;
    cycle();
    flag_clr = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] sel, input logic [7:0] d);
    cpu_sel = sel;
    data_in = d;
    cpu_wr  = 1'b1;
    exp_q.push_back({ch_addr(int'(sel)), d});
    cycle();
    cpu_wr = 1'b0;
  endtask

  task automatic expect_frame();
    for (int c = 0; c < 4; c++) exp_q.push_back({ch_addr(c), model_q.pop_front()});
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_busy(input int budget, input string tag);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 1);
  endtask

  initial begin
    int base;
    logic [7:0] bv;
    rst = 1'b1; data_in = 8'd0; fifo_wr = 1'b0; fifo_flush = 1'b0;
    div_lo_wr = 1'b0; div_hi_wr = 1'b0; enable = 1'b0; cpu_wr = 1'b0;
    cpu_sel = 2'd0; flag_clr = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_sdrv_wr", sdrv_wr, 0);
    check("rst_sdrv_addr", sdrv_addr, 16'h000F);
    check("rst_sdrv_data", sdrv_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_full", fifo_full, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overflow", overflow, 0);

    // Frame issue
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    @(negedge clk);
    check("push_level", fifo_level, 4);
    check("push_empty", fifo_empty, 0);
    set_div(16'd9);
    expect_frame();
    base = wr_cyc.size();
    enable = 1'b1;
    wait_drain(40, "frame_drain");
    check("frame_back_to_back", wr_cyc[base+3] - wr_cyc[base], 3);
    check("frame_level", fifo_level, 0);
    check("frame_busy", busy, 0);
    enable = 1'b0;

    // Direct CPU writes with random channel and data
    for (int i = 0; i < 6; i++) cpu_write(2'($urandom_range(0, 3)), 8'($urandom));
    wait_drain(5, "cpu_direct_drain");

    // Rate: 3 preloaded frames at DIV = 99, then a starved tick
    set_div(16'd99);
    pulse_flag_clr();
    repeat (12) push_byte(8'($urandom));
    repeat (3) expect_frame();
    base = wr_cyc.size();
    enable = 1'b1;
    wait_drain(400, "rate_drain");
    check("rate_gap_1", wr_cyc[base+4] - wr_cyc[base], 100);
    check("rate_gap_2", wr_cyc[base+8] - wr_cyc[base+4], 100);
    check("rate_no_underrun", underrun, 0);
    repeat (100) @(negedge clk);
    check("rate_underrun", underrun, 1);
    check("rate_no_extra_wr", wr_cyc.size() - base, 12);
    pulse_flag_clr();
    @(negedge clk);
    check("rate_flag_clr", underrun, 0);
    enable = 1'b0;

    // Arbitration: CPU write in the cycle ch1 would issue
    set_div(16'd9);
    repeat (4) push_byte(8'($urandom));
    exp_q.push_back({ch_addr(0), model_q[0]});
    exp_q.push_back({16'h004F, 8'hA5});
    for (int c = 1; c < 4; c++) exp_q.push_back({ch_addr(c), model_q[c]});
    model_q.delete();
    base = wr_cyc.size();
    enable = 1'b1;
    wait_busy(30, "arb_busy");
    cycle();
    cpu_sel = 2'd2; data_in = 8'hA5; cpu_wr = 1'b1;
    cycle();
    cpu_wr = 1'b0;
    wait_drain(20, "arb_drain");
    check("arb_span", wr_cyc[base+4] - wr_cyc[base], 4);
    check("arb_level", fifo_level, 0);
    enable = 1'b0;

    // Full / overflow, then push+pop while full
    pulse_flag_clr();
    repeat (17) push_byte(8'($urandom));
    @(negedge clk);
    check("full_flag", fifo_full, 1);
    check("full_level", fifo_level, 16);
    check("full_overflow", overflow, 1);
    pulse_flag_clr();
    @(negedge clk);
    check("ovf_clr", overflow, 0);
    expect_frame();
    enable = 1'b1;
    wait_busy(30, "pp_busy");
    for (int i = 0; i < 4; i++) begin
      bv = 8'($urandom);
      data_in = bv;
      fifo_wr = 1'b1;
      model_q.push_back(bv);
      @(negedge clk);
      check("pushpop_level", fifo_level, 16);
    end
    fifo_wr = 1'b0;
    check("pushpop_overflow", overflow, 0);
    repeat (4) expect_frame();
    wait_drain(120, "full_drain");
    check("full_drain_level", fifo_level, 0);
    check("full_drain_empty", fifo_empty, 1);
    enable = 1'b0;

    // Flush mid-frame
    pulse_flag_clr();
    repeat (8) push_byte(8'($urandom));
    exp_q.push_back({ch_addr(0), model_q[0]});
    model_q.delete();
    base = wr_cyc.size();
    enable = 1'b1;
    wait_busy(30, "flush_busy");
    cycle();
    fifo_flush = 1'b1;
    cycle();
    fifo_flush = 1'b0;
    @(negedge clk);
    check("flush_level", fifo_level, 0);
    check("flush_busy_low", busy, 0);
    check("flush_empty", fifo_empty, 1);
    check("flush_underrun_before", underrun, 0);
    repeat (15) @(negedge clk);
    check("flush_underrun", underrun, 1);
    check("flush_writes", wr_cyc.size() - base, 1);
    check("flush_exp", exp_q.size(), 0);
    enable = 1'b0;

    // Reset during ch2
    repeat (17) push_byte(8'($urandom));
    @(negedge clk);
    check("pre_rst_overflow", overflow, 1);
    check("pre_rst_underrun", underrun, 1);
    exp_q.push_back({ch_addr(0), model_q[0]});
    exp_q.push_back({ch_addr(1), model_q[1]});
    model_q.delete();
    enable = 1'b1;
    wait_busy(30, "rst_busy");
    cycle();
    cycle();
    rst = 1'b1;
    enable = 1'b0;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_sdrv_wr", sdrv_wr, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_exp", exp_q.size(), 0);

    // Divisor back at its reset value: frames 875 cycles apart
    repeat (8) push_byte(8'($urandom));
    repeat (2) expect_frame();
    base = wr_cyc.size();
    enable = 1'b1;
    wait_drain(1900, "div_rst_drain");
    check("div_rst_period", wr_cyc[base+4] - wr_cyc[base], 875);
    enable = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
